decode_stage: RTL and testbench

Registered, parametrised successor to the combinational RISC-V decoder. It sits between fetch and execute as a one-entry pipeline stage with valid/ready handshakes on both sides. It decodes a full 32-bit instruction into ALU/RAM/writeback/PC controls plus register indices, and flags illegal encodings. It also stalls fetch for multi-cycle loads and M-extension ops, and supports a flush for taken branches and jumps.

---
 rtl/decode_stage.sv | 255 +++++++++++++++++++++++++
 tb/tb_decode_stage.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_stage.sv
`default_nettype none
// ============================================================================
//  Module   : decode_stage
//  Purpose  : One-entry registered RISC-V decode stage with valid/ready on
//             both sides, multi-cycle load / mul-div stall and flush.
//  Revision : 1.0  initial release
// ============================================================================
module decode_stage #(
    parameter int MULDIV_EN     = 1,
    parameter int LOAD_CYCLES   = 2,
    parameter int MULDIV_CYCLES = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] instr,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        flush,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [3:0]  AluOp,
    output logic        regw,
    output logic        ramR,
    output logic        ramW,
    output logic        sext,
    output logic        muldiv,
    output logic [2:0]  imm,
    output logic [1:0]  writesel,
    output logic [1:0]  pcsel,
    output logic [4:0]  rd,
    output logic [4:0]  rs1,
    output logic [4:0]  rs2,
    output logic        illegal
);

    localparam int MAX_CYCLES = (LOAD_CYCLES > MULDIV_CYCLES) ? LOAD_CYCLES : MULDIV_CYCLES;
    localparam int CW         = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;

    localparam logic [CW-1:0] C_LOAD_HOLD   = CW'(LOAD_CYCLES - 1);
    localparam logic [CW-1:0] C_MULDIV_HOLD = CW'(MULDIV_CYCLES - 1);
    localparam logic          C_LOAD_MULTI  = (LOAD_CYCLES > 1);
    localparam logic          C_MD_MULTI    = (MULDIV_CYCLES > 1);

    localparam logic [6:0] C_OP_RALU     = 7'b0110011;
    localparam logic [6:0] C_OP_IALU     = 7'b0010011;
    localparam logic [6:0] C_OP_ILOAD    = 7'b0000011;
    localparam logic [6:0] C_OP_SSTORE   = 7'b0100011;
    localparam logic [6:0] C_OP_ULOAD    = 7'b0110111;
    localparam logic [6:0] C_OP_UPC      = 7'b0010111;
    localparam logic [6:0] C_OP_IJUMP    = 7'b1100111;
    localparam logic [6:0] C_OP_SBBRANCH = 7'b1100011;
    localparam logic [6:0] C_OP_UJJUMP   = 7'b1101111;

    localparam logic [0:0] ST_RUN  = 1'b0;
    localparam logic [0:0] ST_HOLD = 1'b1;

    typedef struct packed {
        logic [3:0] alu_op;
        logic       regw;
        logic       ram_r;
        logic       ram_w;
        logic       sext;
        logic       muldiv;
        logic [2:0] imm;
        logic [1:0] writesel;
        logic [1:0] pcsel;
        logic       illegal;
    } ctrl_t;

    ctrl_t           dec_ctrl;
    ctrl_t           ctrl_q;
    logic            valid_q;
    logic [4:0]      rd_q;
    logic [4:0]      rs1_q;
    logic [4:0]      rs2_q;
    logic [0:0]      state_q;
    logic [0:0]      state_d;
    logic [CW-1:0]   hold_cnt_q;
    logic [CW-1:0]   hold_cnt_d;
    logic            held_multi;
    logic [CW-1:0]   held_hold_len;
    logic            accept;
    logic            out_hs;

    wire logic [6:0] opcode = instr[6:0];
    wire logic [2:0] funct3 = instr[14:12];
    wire logic [6:0] funct7 = instr[31:25];

    // Combinational decode of the incoming word
    always_comb begin
        dec_ctrl = '0;
        case (opcode)
            C_OP_RALU: begin
                if (funct7 == 7'd1) begin
                    if (MULDIV_EN != 0) begin
                        dec_ctrl.regw     = 1'b1;
                        dec_ctrl.muldiv   = 1'b1;
                        dec_ctrl.writesel = 2'b11;
                    end else begin
                        dec_ctrl.illegal  = 1'b1;
                    end
                end else begin
                    dec_ctrl.regw   = 1'b1;
                    dec_ctrl.alu_op = {funct3, funct7[5]};
                end
            end
            C_OP_IALU: begin
                dec_ctrl.regw = 1'b1;
                if (funct3 == 3'b001 || funct3 == 3'b101) begin
                    dec_ctrl.alu_op = {funct3, funct7[5]};
                    dec_ctrl.imm    = 3'b010;
                    // Logical right shift is the only shift that must not sign-extend
                    dec_ctrl.sext   = ({funct3, funct7[5]} != 4'b1010);
                end else if (funct3 == 3'b011) begin
                    dec_ctrl.alu_op = 4'b0110;
                    dec_ctrl.imm    = 3'b001;
                    dec_ctrl.sext   = 1'b0;
                end else begin
                    dec_ctrl.alu_op = {funct3, 1'b0};
                    dec_ctrl.imm    = 3'b001;
                    dec_ctrl.sext   = 1'b1;
                end
            end
            C_OP_ILOAD: begin
                dec_ctrl.imm      = 3'b001;
                dec_ctrl.ram_r    = 1'b1;
                dec_ctrl.regw     = 1'b1;
                dec_ctrl.writesel = 2'b01;
            end
            C_OP_SSTORE: begin
                dec_ctrl.imm      = 3'b011;
                dec_ctrl.ram_w    = 1'b1;
                dec_ctrl.writesel = 2'b01;
            end
            C_OP_ULOAD, C_OP_UPC: begin
                dec_ctrl.imm  = 3'b100;
                dec_ctrl.regw = 1'b1;
            end
            C_OP_IJUMP: begin
                dec_ctrl.imm      = 3'b001;
                dec_ctrl.pcsel    = 2'b01;
                dec_ctrl.regw     = 1'b1;
                dec_ctrl.writesel = 2'b10;
            end
            C_OP_SBBRANCH: begin
                dec_ctrl.imm   = 3'b101;
                dec_ctrl.pcsel = 2'b10;
            end
            C_OP_UJJUMP: begin
                dec_ctrl.imm      = 3'b110;
                dec_ctrl.pcsel    = 2'b11;
                dec_ctrl.regw     = 1'b1;
                dec_ctrl.writesel = 2'b10;
            end
            default: begin
                dec_ctrl.illegal = 1'b1;
            end
        endcase
    end

    // Properties of the entry currently held at the output
    assign held_multi    = (ctrl_q.ram_r & C_LOAD_MULTI) | (ctrl_q.muldiv & C_MD_MULTI);
    assign held_hold_len = ctrl_q.ram_r ? C_LOAD_HOLD : C_MULDIV_HOLD;

    assign out_hs = valid_q & out_ready;
    assign accept = in_valid & in_ready;

    // FSM: state register
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= ST_RUN;
            hold_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            hold_cnt_q <= hold_cnt_d;
        end
    end

    // FSM: next state
    always_comb begin
        state_d    = state_q;
        hold_cnt_d = hold_cnt_q;
        if (flush) begin
            state_d    = ST_RUN;
            hold_cnt_d = '0;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (out_hs && held_multi) begin
                        state_d    = ST_HOLD;
                        hold_cnt_d = held_hold_len;
                    end
                end
                ST_HOLD: begin
                    if (hold_cnt_q <= CW'(1)) begin
                        state_d    = ST_RUN;
                        hold_cnt_d = '0;
                    end else begin
                        hold_cnt_d = hold_cnt_q - CW'(1);
                    end
                end
                default: begin
                    state_d    = ST_RUN;
                    hold_cnt_d = '0;
                end
            endcase
        end
    end

    // FSM: outputs
    always_comb begin
        in_ready = 1'b0;
        if (!reset && !flush && (state_q == ST_RUN)) begin
            in_ready = !valid_q || (out_ready && !held_multi);
        end
    end

    // Output entry; flush only drops validity so the last controls stay visible
    always_ff @(posedge clock) begin
        if (reset) begin
            valid_q <= 1'b0;
            ctrl_q  <= '0;
            rd_q    <= '0;
            rs1_q   <= '0;
            rs2_q   <= '0;
        end else if (flush) begin
            valid_q <= 1'b0;
        end else if (accept) begin
            valid_q <= 1'b1;
            ctrl_q  <= dec_ctrl;
            rd_q    <= instr[11:7];
            rs1_q   <= instr[19:15];
            rs2_q   <= instr[24:20];
        end else if (out_hs) begin
            valid_q <= 1'b0;
        end
    end

    assign out_valid = valid_q;
    assign AluOp     = ctrl_q.alu_op;
    assign regw      = ctrl_q.regw;
    assign ramR      = ctrl_q.ram_r;
    assign ramW      = ctrl_q.ram_w;
    assign sext      = ctrl_q.sext;
    assign muldiv    = ctrl_q.muldiv;
    assign imm       = ctrl_q.imm;
    assign writesel  = ctrl_q.writesel;
    assign pcsel     = ctrl_q.pcsel;
    assign illegal   = ctrl_q.illegal;
    assign rd        = rd_q;
    assign rs1       = rs1_q;
    assign rs2       = rs2_q;

endmodule
`default_nettype wire

// File: tb/tb_decode_stage.sv
`default_nettype none
// ============================================================================
//  Module   : tb_decode_stage
//  Purpose  : Self-checking bench for decode_stage; two parameter sets driven
//             by shared stimulus and checked against a behavioural model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_decode_stage;

    typedef struct packed {
        logic [3:0] alu;
        logic       regw;
        logic       ramr;
        logic       ramw;
        logic       sext;
        logic       md;
        logic [2:0] imm;
        logic [1:0] ws;
        logic [1:0] pc;
        logic [4:0] rd;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       ill;
    } ent_t;

    localparam logic [31:0] I_ADD   = 32'h003100B3;
    localparam logic [31:0] I_ADDI  = 32'h00510093;
    localparam logic [31:0] I_SRAI  = 32'h40315093;
    localparam logic [31:0] I_SLTIU = 32'h00713093;
    localparam logic [31:0] I_LW    = 32'h00012283;
    localparam logic [31:0] I_MUL   = 32'h023100B3;
    localparam logic [31:0] I_JAL   = 32'h000000EF;
    localparam logic [31:0] I_BAD   = 32'h0000007F;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b1;
    logic [31:0] instr = 32'h0;
    logic        chk_en = 1'b0;

    logic        ir   [2];
    logic        ov   [2];
    logic [3:0]  alu  [2];
    logic        regw [2];
    logic        ramr [2];
    logic        ramw [2];
    logic        sext [2];
    logic        md   [2];
    logic [2:0]  imm  [2];
    logic [1:0]  ws   [2];
    logic [1:0]  pc   [2];
    logic [4:0]  rd   [2];
    logic [4:0]  rs1  [2];
    logic [4:0]  rs2  [2];
    logic        ill  [2];
    ent_t        dent [2];

    int tests = 0;
    int fails = 0;

    // Model state per instance (0: EN=1,L=3,M=4   1: EN=0,L=1,M=1)
    int   LC  [2] = '{3, 1};
    int   MC  [2] = '{4, 1};
    int   MEN [2] = '{1, 0};
    logic mv    [2] = '{1'b0, 1'b0};
    ent_t me    [2] = '{32'h0, 32'h0};
    int   stall [2] = '{0, 0};
    logic mr;
    logic mhs;

    always #5 clk = ~clk;

    decode_stage #(.MULDIV_EN(1), .LOAD_CYCLES(3), .MULDIV_CYCLES(4)) dut_a (
        .clock(clk), .reset(reset), .instr(instr), .in_valid(in_valid),
        .in_ready(ir[0]), .flush(flush), .out_valid(ov[0]), .out_ready(out_ready),
        .AluOp(alu[0]), .regw(regw[0]), .ramR(ramr[0]), .ramW(ramw[0]),
        .sext(sext[0]), .muldiv(md[0]), .imm(imm[0]), .writesel(ws[0]),
        .pcsel(pc[0]), .rd(rd[0]), .rs1(rs1[0]), .rs2(rs2[0]), .illegal(ill[0])
    );

    decode_stage #(.MULDIV_EN(0), .LOAD_CYCLES(1), .MULDIV_CYCLES(1)) dut_b (
        .clock(clk), .reset(reset), .instr(instr), .in_valid(in_valid),
        .in_ready(ir[1]), .flush(flush), .out_valid(ov[1]), .out_ready(out_ready),
        .AluOp(alu[1]), .regw(regw[1]), .ramR(ramr[1]), .ramW(ramw[1]),
        .sext(sext[1]), .muldiv(md[1]), .imm(imm[1]), .writesel(ws[1]),
        .pcsel(pc[1]), .rd(rd[1]), .rs1(rs1[1]), .rs2(rs2[1]), .illegal(ill[1])
    );

    for (genvar gi = 0; gi < 2; gi++) begin : g_ent
        assign dent[gi] = {alu[gi], regw[gi], ramr[gi], ramw[gi], sext[gi], md[gi],
                           imm[gi], ws[gi], pc[gi], rd[gi], rs1[gi], rs2[gi], ill[gi]};
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Decode table straight from the instruction-set rules
    function automatic ent_t mdec(input logic [31:0] w, input int men);
        ent_t       e;
        logic [2:0] f3;
        logic [6:0] f7;
        e   = '0;
        f3  = w[14:12];
        f7  = w[31:25];
        e.rd  = w[11:7];
        e.rs1 = w[19:15];
        e.rs2 = w[24:20];
        case (w[6:0])
            7'h33: begin
                if (f7 == 7'd1) begin
                    if (men != 0) begin e.regw = 1; e.md = 1; e.ws = 2'd3; end
                    else e.ill = 1;
                end else begin
                    e.regw = 1; e.alu = {f3, f7[5]};
                end
            end
            7'h13: begin
                e.regw = 1;
                if (f3 == 3'd1 || f3 == 3'd5) begin
                    e.alu = {f3, f7[5]}; e.imm = 3'd2;
                    e.sext = (f3 == 3'd5 && f7[5] == 1'b0) ? 1'b0 : 1'b1;
                end else if (f3 == 3'd3) begin
                    e.alu = 4'd6; e.imm = 3'd1; e.sext = 0;
                end else begin
                    e.alu = {f3, 1'b0}; e.imm = 3'd1; e.sext = 1;
                end
            end
            7'h03: begin e.imm = 3'd1; e.ramr = 1; e.regw = 1; e.ws = 2'd1; end
            7'h23: begin e.imm = 3'd3; e.ramw = 1; e.ws = 2'd1; end
            7'h37, 7'h17: begin e.imm = 3'd4; e.regw = 1; end
            7'h67: begin e.imm = 3'd1; e.pc = 2'd1; e.regw = 1; e.ws = 2'd2; end
            7'h63: begin e.imm = 3'd5; e.pc = 2'd2; end
            7'h6F: begin e.imm = 3'd6; e.pc = 2'd3; e.regw = 1; e.ws = 2'd2; end
            default: e.ill = 1;
        endcase
        return e;
    endfunction

    function automatic logic mmulti(input int i, input ent_t e);
        return (e.ramr && LC[i] > 1) || (e.md && MC[i] > 1);
    endfunction

    function automatic logic mready(input int i);
        if (reset || flush || stall[i] != 0) return 1'b0;
        return !mv[i] || (out_ready && !mmulti(i, me[i]));
    endfunction

    function automatic ent_t ctrl_only(input ent_t e);
        ent_t x;
        x = e;
        x.rd = '0; x.rs1 = '0; x.rs2 = '0;
        return x;
    endfunction

    // Cycle-by-cycle comparison, then advance the model with this cycle's inputs
    always @(negedge clk) begin
        if (chk_en) begin
            for (int i = 0; i < 2; i++) begin
                mr  = mready(i);
                mhs = mv[i] && out_ready;
                chk($sformatf("in_ready[%0d]", i), 64'(ir[i]), 64'(mr));
                chk($sformatf("out_valid[%0d]", i), 64'(ov[i]), 64'(mv[i]));
                chk($sformatf("entry[%0d]", i), 64'(dent[i]), 64'(me[i]));
                if (reset) begin
                    mv[i] = 1'b0; me[i] = '0; stall[i] = 0;
                end else if (flush) begin
                    mv[i] = 1'b0; stall[i] = 0;
                end else begin
                    if (stall[i] > 0) stall[i] = stall[i] - 1;
                    if (mhs && mmulti(i, me[i]))
                        stall[i] = (me[i].ramr ? LC[i] : MC[i]) - 1;
                    if (in_valid && mr) begin
                        mv[i] = 1'b1; me[i] = mdec(instr, MEN[i]);
                    end else if (mhs) begin
                        mv[i] = 1'b0;
                    end
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] rand_instr();
        logic [6:0]  ops [10];
        logic [31:0] r;
        logic [6:0]  f7;
        int          k;
        ops = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h37, 7'h17, 7'h67, 7'h63, 7'h6F, 7'h00};
        ops[9] = 7'($urandom);
        r = $urandom;
        k = $urandom_range(0, 3);
        f7 = (k == 0) ? 7'h00 : (k == 1) ? 7'h20 : (k == 2) ? 7'h01 : r[31:25];
        return {f7, r[24:7], ops[$urandom_range(0, 9)]};
    endfunction

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int   cnt;
        ent_t x;
        step();
        chk_en = 1'b1;
        step();
        step();
        reset = 1'b0;

        // Single add
        in_valid = 1'b1; instr = I_ADD;
        step();
        chk("add_valid", 64'(ov[0]), 64'd1);
        chk("add_alu", 64'(alu[0]), 64'h0);
        chk("add_regw_ws", 64'({regw[0], ws[0]}), 64'b100);
        chk("add_regs", 64'({rd[0], rs1[0], rs2[0]}), 64'({5'd1, 5'd2, 5'd3}));

        // Back-to-back I-type ops
        instr = I_ADDI;  step();
        chk("addi_fields", 64'({alu[0], sext[0], imm[0]}), 64'({4'b0000, 1'b1, 3'b001}));
        instr = I_SRAI;  step();
        chk("srai_fields", 64'({alu[0], sext[0], imm[0]}), 64'({4'b1011, 1'b1, 3'b010}));
        instr = I_SLTIU; step();
        chk("sltiu_fields", 64'({alu[0], sext[0], imm[0]}), 64'({4'b0110, 1'b0, 3'b001}));
        in_valid = 1'b0; step();

        // Load with 3-cycle latency followed by addi
        in_valid = 1'b1; instr = I_LW; step();
        instr = I_ADDI;
        cnt = 0;
        while (ir[0] !== 1'b1 && cnt < 10) begin cnt++; step(); end
        chk("lw_stall_cycles", 64'(cnt), 64'd3);
        step();
        chk("addi_after_lw", 64'({ov[0], alu[0], imm[0]}), 64'({1'b1, 4'b0000, 3'b001}));
        in_valid = 1'b0; step();

        // Mul with 4-cycle latency; instance b must flag it illegal
        in_valid = 1'b1; instr = I_MUL; step();
        chk("mul_md_ws", 64'({md[0], ws[0]}), 64'({1'b1, 2'b11}));
        x = '0; x.ill = 1'b1;
        chk("mul_illegal_b", 64'(ctrl_only(dent[1])), 64'(x));
        chk("mul_illegal_b_valid", 64'(ov[1]), 64'd1);
        instr = I_ADDI;
        cnt = 0;
        while (ir[0] !== 1'b1 && cnt < 10) begin cnt++; step(); end
        chk("mul_stall_cycles", 64'(cnt), 64'd4);
        step();
        in_valid = 1'b0; step();

        // Jal held under back-pressure
        in_valid = 1'b1; instr = I_JAL; out_ready = 1'b0; step();
        instr = I_ADDI;
        for (int k = 0; k < 5; k++) begin
            chk("jal_hold", 64'({ov[0], ir[0], pc[0], imm[0], ws[0]}),
                64'({1'b1, 1'b0, 2'b11, 3'b110, 2'b10}));
            step();
        end
        out_ready = 1'b1;
        #1;
        chk("jal_release_ready", 64'(ir[0]), 64'd1);
        step();
        chk("addi_after_jal", 64'({ov[0], pc[0], imm[0]}), 64'({1'b1, 2'b00, 3'b001}));
        in_valid = 1'b0; step();

        // Undecodable opcode
        in_valid = 1'b1; instr = I_BAD; step();
        x = '0; x.ill = 1'b1;
        chk("bad_opcode", 64'({ov[0], ctrl_only(dent[0])}), 64'({1'b1, x}));
        in_valid = 1'b0; step();

        // Flush in the middle of a mul hold
        in_valid = 1'b1; instr = I_MUL; step();
        in_valid = 1'b0; step(); step();
        flush = 1'b1;
        #1;
        chk("flush_cycle_ready", 64'(ir[0]), 64'd0);
        step();
        flush = 1'b0;
        #1;
        chk("after_flush", 64'({ir[0], ov[0], md[0]}), 64'b101);
        step();

        // Reset in the middle of a mul hold
        in_valid = 1'b1; instr = I_MUL; step();
        in_valid = 1'b0; step(); step();
        reset = 1'b1; step();
        reset = 1'b0;
        #1;
        chk("after_reset", 64'({ir[0], ov[0], dent[0]}), 64'({1'b1, 1'b0, 32'h0}));
        step();

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            reset     = ($urandom_range(0, 199) == 0);
            flush     = ($urandom_range(0, 24) == 0);
            out_ready = ($urandom_range(0, 9) < 7);
            in_valid  = ($urandom_range(0, 9) < 7);
            instr     = rand_instr();
            step();
        end
        reset = 1'b0; flush = 1'b0; in_valid = 1'b0;
        step();
        chk_en = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
